// File: rtl/audio_pkg.sv
// Shared types and constants for the audio output stage, plus the
// amplitude-to-duty scaling used by audio_pwm_out.
package audio_pkg;

  typedef enum logic [1:0] {
    ENV_IDLE,
    ENV_ATTACK,
    ENV_SUSTAIN,
    ENV_RELEASE
  } env_state_t;

  localparam logic [3:0] LEVEL_MAX = 4'd15;
  localparam logic [7:0] PWM_MID   = 8'd128;

  // Signed 8x5 product, arithmetic shift by 4, then re-bias by flipping the MSB
  // so that -120..119 maps onto duty 8..247 around PWM_MID.
  function automatic logic [7:0] scale_to_duty(input logic [7:0] smp,
                                               input logic [3:0] lvl);
    logic signed [12:0] smp_ext;
    logic signed [12:0] lvl_ext;
    logic signed [12:0] product;
    logic signed [12:0] scaled;
    smp_ext = {{5{smp[7]}}, smp};
    lvl_ext = {9'd0, lvl};
    product = smp_ext * lvl_ext;
    scaled  = product >>> 4;
    return {~scaled[7], scaled[6:0]};
  endfunction

endpackage

// File: rtl/pwm_modulator.sv
// 8-bit PWM: free-running counter, duty reloaded only at the period boundary
// so a duty change never produces a truncated or doubled pulse.
module pwm_modulator
  import audio_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [7:0] duty_in,
  output logic       pwm_out
);

  logic [7:0] pwm_cnt;
  logic [7:0] duty_act;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pwm_cnt  <= '0;
      duty_act <= PWM_MID;
      pwm_out  <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (pwm_cnt == 8'd255) begin
        duty_act <= duty_in;
      end
      pwm_out <= (pwm_cnt < duty_act);
    end
  end

endmodule

// File: rtl/audio_pwm_out.sv
// Audio output stage: sample strobe divider, amplitude capture, attack/release
// envelope and volume scaling feeding the PWM modulator.
module audio_pwm_out #(
  parameter int CLK_DIV          = 8333,
  parameter int ENV_STEP_SAMPLES = 48
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       gate_in,
  input  logic [7:0] amp_in,
  output logic       step_out,
  output logic       pwm_out,
  output logic [3:0] level_out,
  output logic       busy_out
);

  import audio_pkg::*;

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int ENV_W = $clog2(ENV_STEP_SAMPLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] CAPTURE_AT = DIV_W'(3);
  localparam logic [ENV_W-1:0] ENV_LAST   = ENV_W'(ENV_STEP_SAMPLES - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [7:0]       sample;
  logic             capture_d;
  logic [7:0]       duty_next;

  env_state_t       state, state_nxt;
  logic [3:0]       level, level_nxt;
  logic [ENV_W-1:0] env_cnt, env_cnt_nxt;
  logic             env_tick;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      div_cnt   <= '0;
      step_out  <= 1'b0;
      sample    <= '0;
      capture_d <= 1'b0;
      duty_next <= PWM_MID;
    end else begin
      div_cnt   <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      step_out  <= (div_cnt == DIV_LAST);
      capture_d <= (div_cnt == CAPTURE_AT);
      // Capture three cycles into the sample period, once the generator's
      // phase update and registered LUT have settled.
      if (div_cnt == CAPTURE_AT) begin
        sample <= amp_in;
      end
      if (capture_d) begin
        duty_next <= scale_to_duty(sample, level);
      end
    end
  end

  assign env_tick = step_out && (env_cnt == ENV_LAST);

  // NOTE: every combinational output gets a default first, so no path through
  // the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    level_nxt = level;
    case (state)
      ENV_IDLE: begin
        level_nxt = '0;
        if (gate_in) state_nxt = ENV_ATTACK;
      end
      ENV_ATTACK: begin
        if (!gate_in) begin
          state_nxt = ENV_RELEASE;
        end else if (env_tick) begin
          if (level >= LEVEL_MAX - 4'd1) begin
            level_nxt = LEVEL_MAX;
            state_nxt = ENV_SUSTAIN;
          end else begin
            level_nxt = level + 4'd1;
          end
        end
      end
      ENV_SUSTAIN: begin
        if (!gate_in) state_nxt = ENV_RELEASE;
      end
      ENV_RELEASE: begin
        // Re-trigger resumes the attack from the current level.
        if (gate_in) begin
          state_nxt = ENV_ATTACK;
        end else if (env_tick) begin
          if (level <= 4'd1) begin
            level_nxt = '0;
            state_nxt = ENV_IDLE;
          end else begin
            level_nxt = level - 4'd1;
          end
        end
      end
      default: begin
        state_nxt = ENV_IDLE;
        level_nxt = '0;
      end
    endcase

    // A transition restarts the envelope step timing; a gate change that
    // coincides with a tick therefore also swallows that tick's level change.
    env_cnt_nxt = env_cnt;
    if (state_nxt != state) begin
      env_cnt_nxt = '0;
    end else if (step_out) begin
      env_cnt_nxt = env_tick ? '0 : env_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= ENV_IDLE;
      level    <= '0;
      env_cnt  <= '0;
      busy_out <= 1'b0;
    end else begin
      state    <= state_nxt;
      level    <= level_nxt;
      env_cnt  <= env_cnt_nxt;
      busy_out <= (state_nxt != ENV_IDLE);
    end
  end

  assign level_out = level;

  pwm_modulator u_pwm (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .duty_in  (duty_next),
    .pwm_out  (pwm_out)
  );

endmodule
